// File: rtl/rapid_pipeline_sequencer_if.sv
// ---------------------------------------------------------------------------
// rapid_pipeline_sequencer_if
// Bundles the stage-side signals of the rapid pipeline sequencer.
//
// Handshake: the i_stage_done vector is the "valid" side. Every stage raises
// its bit when its work for the current instruction slot is complete.
// o_pipeline_ready is the "ready" side. It is a one-cycle strobe. A transfer
// (pipeline advance) happens on exactly the cycle in which o_pipeline_ready
// is high, and o_bubble/o_flush qualify that transfer. Stages drop their done
// bit after seeing the strobe. The sequencer ignores i_stage_done outside
// the cycle in which it is waiting for the stages.
//
// Signals
//   i_stage_done       per-stage done flags, bit0=IF ... bit4=WB
//   i_stall_req        external hold, inhibits advance while high
//   i_pc_load          EX redirect (taken branch/jump)
//   i_de_rs1/_rs2      DE source registers, with *_used qualifiers
//   i_ex_rd/i_mem_rd   EX/MEM destination registers, with *_we qualifiers
//   o_pipeline_ready   advance strobe
//   o_bubble/o_flush   qualifiers of the advance strobe
//   o_timeout          sticky watchdog flag
//   o_state            debug view of the sequencer FSM
//   o_*_count          performance counters
// Modports
//   master  the sequencer
//   slave   the pipeline stages (or a testbench standing in for them)
// ---------------------------------------------------------------------------
interface rapid_pipeline_sequencer_if #(
  parameter int NUM_STAGES = 5,
  parameter int REG_ADDR_W = 5,
  parameter int COUNT_W    = 32
);
  logic [NUM_STAGES-1:0] i_stage_done;
  logic                  i_stall_req;
  logic                  i_pc_load;
  logic [REG_ADDR_W-1:0] i_de_rs1;
  logic [REG_ADDR_W-1:0] i_de_rs2;
  logic                  i_de_rs1_used;
  logic                  i_de_rs2_used;
  logic [REG_ADDR_W-1:0] i_ex_rd;
  logic [REG_ADDR_W-1:0] i_mem_rd;
  logic                  i_ex_rd_we;
  logic                  i_mem_rd_we;

  logic                  o_pipeline_ready;
  logic                  o_bubble;
  logic                  o_flush;
  logic                  o_timeout;
  logic [1:0]            o_state;
  logic [COUNT_W-1:0]    o_advance_count;
  logic [COUNT_W-1:0]    o_bubble_count;
  logic [COUNT_W-1:0]    o_flush_count;

  modport master (
    input  i_stage_done, i_stall_req, i_pc_load,
           i_de_rs1, i_de_rs2, i_de_rs1_used, i_de_rs2_used,
           i_ex_rd, i_mem_rd, i_ex_rd_we, i_mem_rd_we,
    output o_pipeline_ready, o_bubble, o_flush, o_timeout, o_state,
           o_advance_count, o_bubble_count, o_flush_count
  );

  modport slave (
    output i_stage_done, i_stall_req, i_pc_load,
           i_de_rs1, i_de_rs2, i_de_rs1_used, i_de_rs2_used,
           i_ex_rd, i_mem_rd, i_ex_rd_we, i_mem_rd_we,
    input  o_pipeline_ready, o_bubble, o_flush, o_timeout, o_state,
           o_advance_count, o_bubble_count, o_flush_count
  );
endinterface

// File: rtl/rapid_pipeline_sequencer.sv
// ---------------------------------------------------------------------------
// rapid_pipeline_sequencer
// Central pipeline controller of the rapid core. It waits until every stage
// reports done and no external stall is requested. Then it issues a one-cycle
// advance strobe, qualified by a bubble (RAW hazard on a DE operand) or a
// flush (EX redirect). A watchdog moves the controller to a terminal HALT
// state when the stages stay stuck for too long.
//
// Ports
//   i_clk    core clock, rising edge
//   i_reset  synchronous, active-low reset
//   bus      rapid_pipeline_sequencer_if.master (stage handshake, hazard
//            operands, strobe/qualifiers, timeout, debug state, counters)
//
// Parameters
//   NUM_STAGES       number of stage done bits (all must be high to advance)
//   REG_ADDR_W       register index width
//   WATCHDOG_CYCLES  stalled WAIT cycles before HALT, 0 disables the watchdog
//   COUNT_W          performance counter width
//
// Build option
//   RAPID_PERF_COUNTERS_EN  when defined, advance/bubble/flush counters are
//                           implemented (wrapping). Otherwise the counter
//                           outputs are constant 0 and no flops are built.
// ---------------------------------------------------------------------------
module rapid_pipeline_sequencer #(
  parameter int NUM_STAGES      = 5,
  parameter int REG_ADDR_W      = 5,
  parameter int WATCHDOG_CYCLES = 255,
  parameter int COUNT_W         = 32
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  rapid_pipeline_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ADVANCE = 2'd2,
    S_HALT    = 2'd3
  } state_e;

  // Watchdog counter sized to hold WATCHDOG_CYCLES itself.
  localparam int WD_W = (WATCHDOG_CYCLES > 0) ? $clog2(WATCHDOG_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WATCHDOG_CYCLES);

  state_e            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              bubble_q, bubble_d;
  logic              flush_q, flush_d;

  logic [NUM_STAGES-1:0] done;
  logic [REG_ADDR_W-1:0] rs1, rs2, ex_rd, mem_rd;
  logic                  go;
  logic                  hz_rs1, hz_rs2, hazard;
  logic                  ready;

  assign done   = bus.i_stage_done;
  assign rs1    = bus.i_de_rs1;
  assign rs2    = bus.i_de_rs2;
  assign ex_rd  = bus.i_ex_rd;
  assign mem_rd = bus.i_mem_rd;

  assign go = (&done) & ~bus.i_stall_req;

  // x0 is hardwired to zero, so it can never carry a RAW dependency.
  assign hz_rs1 = bus.i_de_rs1_used && (rs1 != '0) &&
                  ((bus.i_ex_rd_we  && (rs1 == ex_rd)) ||
                   (bus.i_mem_rd_we && (rs1 == mem_rd)));
  assign hz_rs2 = bus.i_de_rs2_used && (rs2 != '0) &&
                  ((bus.i_ex_rd_we  && (rs2 == ex_rd)) ||
                   (bus.i_mem_rd_we && (rs2 == mem_rd)));
  assign hazard = hz_rs1 | hz_rs2;

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    wd_d     = wd_q;
    bubble_d = bubble_q;
    flush_d  = flush_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_WAIT;
        wd_d    = '0;
      end
      S_WAIT: begin
        if (go) begin
          // The redirect wins: the instruction that would stall is flushed anyway.
          state_d  = S_ADVANCE;
          flush_d  = bus.i_pc_load;
          bubble_d = hazard & ~bus.i_pc_load;
        end else if (WATCHDOG_CYCLES != 0) begin
          wd_d = wd_q + WD_W'(1);
          if (wd_d == WD_LIMIT) begin
            state_d = S_HALT;
          end
        end
      end
      S_ADVANCE: begin
        state_d = S_WAIT;
        wd_d    = '0;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q  <= S_IDLE;
      wd_q     <= '0;
      bubble_q <= 1'b0;
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wd_q     <= wd_d;
      bubble_q <= bubble_d;
      flush_q  <= flush_d;
    end
  end

  // Outputs depend only on flops. The qualifiers keep their last sampled
  // value, so they are gated to show only alongside the strobe.
  assign ready                = (state_q == S_ADVANCE);
  assign bus.o_pipeline_ready = ready;
  assign bus.o_bubble         = ready & bubble_q;
  assign bus.o_flush          = ready & flush_q;
  assign bus.o_timeout        = (state_q == S_HALT);
  assign bus.o_state          = state_q;

`ifdef RAPID_PERF_COUNTERS_EN
  logic [COUNT_W-1:0] adv_cnt_q, adv_cnt_d;
  logic [COUNT_W-1:0] bub_cnt_q, bub_cnt_d;
  logic [COUNT_W-1:0] fl_cnt_q,  fl_cnt_d;

  always_comb begin
    adv_cnt_d = adv_cnt_q;
    bub_cnt_d = bub_cnt_q;
    fl_cnt_d  = fl_cnt_q;
    if (ready)        adv_cnt_d = adv_cnt_q + COUNT_W'(1);
    if (bus.o_bubble) bub_cnt_d = bub_cnt_q + COUNT_W'(1);
    if (bus.o_flush)  fl_cnt_d  = fl_cnt_q  + COUNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      adv_cnt_q <= '0;
      bub_cnt_q <= '0;
      fl_cnt_q  <= '0;
    end else begin
      adv_cnt_q <= adv_cnt_d;
      bub_cnt_q <= bub_cnt_d;
      fl_cnt_q  <= fl_cnt_d;
    end
  end

  assign bus.o_advance_count = adv_cnt_q;
  assign bus.o_bubble_count  = bub_cnt_q;
  assign bus.o_flush_count   = fl_cnt_q;
`else
  assign bus.o_advance_count = {COUNT_W{1'b0}};
  assign bus.o_bubble_count  = {COUNT_W{1'b0}};
  assign bus.o_flush_count   = {COUNT_W{1'b0}};
`endif

endmodule
